// File: rtl/maindec_mc.sv
// maindec_mc: multi-cycle LEGv8 main decoder FSM with memory handshake, retire counter and sticky fault flags.
// Define MAINDEC_MC_CBNZ_EN to decode 101_1010_1??? as CBNZ; otherwise that opcode is illegal.
module maindec_mc #(
    parameter int OP_W         = 11,
    parameter int CNT_W        = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [OP_W-1:0]  Op,
    output logic             instr_ready,
    input  logic             mem_ack,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             Uncondbranch,
    output logic [1:0]       ALUOp,
    output logic             PCWrite,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);
    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [2:0] {K_LDUR, K_STUR, K_CBR, K_RTYPE, K_B, K_ILL} cls_t;

    state_t            state, state_n;
    cls_t              cls;
    logic [OP_W-1:0]   op_q;
    logic [WAIT_W-1:0] wcnt;
    logic              is_cbnz, is_rtype, mem_op, timeout_hit;

`ifdef MAINDEC_MC_CBNZ_EN
    assign is_cbnz = op_q ==? 11'b10110101???;
`else
    assign is_cbnz = 1'b0;
`endif

    assign is_rtype = op_q == 11'b10001011000 || op_q == 11'b11001011000 ||
                      op_q == 11'b10001010000 || op_q == 11'b10101010000;

    assign cls = (op_q == 11'b11111000010)              ? K_LDUR  :
                 (op_q == 11'b11111000000)              ? K_STUR  :
                 (op_q ==? 11'b10110100??? || is_cbnz)  ? K_CBR   :
                 is_rtype                               ? K_RTYPE :
                 (op_q ==? 11'b000101?????)             ? K_B     : K_ILL;

    assign mem_op      = cls == K_LDUR || cls == K_STUR;
    assign timeout_hit = state == MEM && !mem_ack && wcnt == WAIT_LAST;

    always_comb begin
        state_n      = state;
        instr_ready  = 1'b0;
        Reg2Loc      = 1'b0;
        ALUSrc       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        ALUOp        = 2'b00;
        PCWrite      = 1'b0;
        // Reset overrides the current state so an abandoned instruction never pulses PCWrite
        if (!reset_n) begin
            instr_ready = 1'b1;
            state_n     = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    instr_ready = 1'b1;
                    state_n     = instr_valid ? DECODE : FETCH;
                end
                DECODE: state_n = (cls == K_ILL) ? HALT : EXEC;
                EXEC: begin
                    ALUSrc       = mem_op;
                    ALUOp        = (cls == K_RTYPE) ? 2'b10 : (cls == K_CBR) ? 2'b01 : 2'b00;
                    Reg2Loc      = cls == K_CBR;
                    Branch       = cls == K_CBR;
                    Uncondbranch = cls == K_B;
                    PCWrite      = cls == K_CBR || cls == K_B;
                    state_n      = mem_op ? MEM : (cls == K_RTYPE) ? WB : FETCH;
                end
                MEM: begin
                    MemRead  = cls == K_LDUR;
                    MemWrite = cls == K_STUR;
                    Reg2Loc  = cls == K_STUR;
                    PCWrite  = mem_ack && cls == K_STUR;
                    state_n  = mem_ack ? ((cls == K_LDUR) ? WB : FETCH) : timeout_hit ? HALT : MEM;
                end
                WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = cls == K_LDUR;
                    PCWrite  = 1'b1;
                    state_n  = FETCH;
                end
                default: state_n = HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FETCH;
            op_q        <= '0;
            wcnt        <= '0;
            retired     <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (state == FETCH && instr_valid) op_q <= Op;
            wcnt <= (state == MEM && !mem_ack) ? wcnt + WAIT_W'(1) : '0;
            if (PCWrite) retired <= retired + CNT_W'(1);
            if (state == DECODE && cls == K_ILL) illegal_op <= 1'b1;
            if (timeout_hit) mem_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_maindec_mc.sv
// tb_maindec_mc: table-driven and randomized checks of maindec_mc against a per-instruction cycle-trace model.
// Honors MAINDEC_MC_CBNZ_EN the same way as the design.
module tb_maindec_mc;
    localparam int CNT_W = 4;
    localparam int MAXW  = 15;
    localparam logic [11:0] RDY = 12'h800, R2L = 12'h400, ASRC = 12'h200, M2R = 12'h100,
                            RW = 12'h080, MR = 12'h040, MW = 12'h020, BR = 12'h010,
                            UB = 12'h008, AOP10 = 12'h004, AOP01 = 12'h002, PCW = 12'h001;
    localparam int K_LD = 0, K_ST = 1, K_CB = 2, K_R = 3, K_B = 4, K_ILL = 5;

    logic clk = 1'b0, reset_n = 1'b0, instr_valid = 1'b0, mem_ack = 1'b0;
    logic [10:0] Op = '0;
    logic instr_ready, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Uncondbranch;
    logic PCWrite, illegal_op, mem_timeout;
    logic [1:0] ALUOp;
    logic [CNT_W-1:0] retired;

    int checks = 0, errors = 0, model_ret = 0;
    logic exp_ill = 1'b0, exp_to = 1'b0;

    maindec_mc #(.OP_W(11), .CNT_W(CNT_W), .MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .Op(Op), .instr_ready(instr_ready),
        .mem_ack(mem_ack), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Uncondbranch(Uncondbranch),
        .ALUOp(ALUOp), .PCWrite(PCWrite), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pack();
        return {instr_ready, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                Branch, Uncondbranch, ALUOp, PCWrite};
    endfunction

    function automatic int kind(logic [10:0] op);
        if (op == 11'b11111000010) return K_LD;
        if (op == 11'b11111000000) return K_ST;
        if (op ==? 11'b10110100???) return K_CB;
`ifdef MAINDEC_MC_CBNZ_EN
        if (op ==? 11'b10110101???) return K_CB;
`endif
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return K_R;
        if (op ==? 11'b000101?????) return K_B;
        return K_ILL;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; instr_valid = 1'($urandom); mem_ack = 1'($urandom); Op = 11'($urandom);
        #1 chk("out_in_reset", 32'(pack()), 32'(RDY));
        @(negedge clk);
        reset_n = 1'b1; instr_valid = 1'b0;
        #1 chk("out_after_reset", 32'(pack()), 32'(RDY));
        chk("retired_reset", 32'(retired), 32'd0);
        chk("flags_reset", {30'd0, illegal_op, mem_timeout}, 32'd0);
        model_ret = 0; exp_ill = 1'b0; exp_to = 1'b0;
    endtask

    // n = MEM cycles including the ack cycle; n = 0 means mem_ack never arrives
    task automatic run_instr(input logic [10:0] op, input int n, output int pc_cyc,
                             output logic [11:0] ew, output bit halted);
        logic [11:0] e[$];
        int a[$];
        int k, cnt;
        bit mem;
        logic [11:0] w;
        k = kind(op); pc_cyc = -1; ew = '0; halted = 1'b0;
        e.push_back(RDY); a.push_back(2);
        e.push_back(12'h000); a.push_back(2);
        if (k == K_ILL) begin
            halted = 1'b1; exp_ill = 1'b1;
        end else begin
            mem = k == K_LD || k == K_ST;
            e.push_back(mem ? ASRC : (k == K_R) ? AOP10 : (k == K_CB) ? (R2L | AOP01 | BR | PCW) : (UB | PCW));
            a.push_back(2);
            if (mem) begin
                cnt = (n == 0) ? MAXW : n;
                for (int i = 0; i < cnt; i++) begin
                    w = (k == K_LD) ? MR : (MW | R2L);
                    if (n != 0 && i == cnt - 1 && k == K_ST) w = w | PCW;
                    e.push_back(w); a.push_back((n != 0 && i == cnt - 1) ? 1 : 0);
                end
                if (n == 0) begin halted = 1'b1; exp_to = 1'b1; end
            end
            if (!halted && (k == K_LD || k == K_R)) begin
                e.push_back(RW | ((k == K_LD) ? M2R : 12'h000) | PCW); a.push_back(2);
            end
        end
        foreach (e[i]) begin
            @(negedge clk);
            instr_valid = (i == 0) ? 1'b1 : 1'($urandom);
            Op = (i == 0) ? op : 11'($urandom);
            mem_ack = (a[i] == 2) ? 1'($urandom) : a[i][0];
            #1;
            w = pack();
            if (i == 2) ew = w;
            if (w[0] && pc_cyc < 0) pc_cyc = i;
            chk($sformatf("cyc%0d_op%b", i, op), 32'(w), 32'(e[i]));
        end
        if (e[e.size()-1][0]) model_ret++;
        @(negedge clk);
        instr_valid = 1'b0; Op = 11'($urandom); mem_ack = 1'($urandom);
        #1 chk("after_instr", 32'(pack()), halted ? 32'd0 : 32'(RDY));
        chk("retired", 32'(retired), 32'(model_ret % 16));
        chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
        chk("mem_timeout", 32'(mem_timeout), 32'(exp_to));
        if (halted) repeat (3) begin
            @(negedge clk);
            instr_valid = 1'b1; Op = 11'($urandom); mem_ack = 1'($urandom);
            #1 chk("halt_absorbing", 32'(pack()), 32'd0);
        end
    endtask

    typedef struct { logic [10:0] op; int n; int lat; logic [11:0] ew; } vec_t;
    vec_t tbl[12];

    initial begin
        int pc;
        logic [11:0] ew;
        bit h;
        logic [10:0] op;
        logic [10:0] rops[4];
        tbl[0]  = '{11'b10001011000, 1, 3, AOP10};
        tbl[1]  = '{11'b11001011000, 1, 3, AOP10};
        tbl[2]  = '{11'b10001010000, 1, 3, AOP10};
        tbl[3]  = '{11'b10101010000, 1, 3, AOP10};
        tbl[4]  = '{11'b10110100101, 1, 2, R2L | AOP01 | BR | PCW};
        tbl[5]  = '{11'b00010100000, 1, 2, UB | PCW};
        tbl[6]  = '{11'b11111000010, 3, 6, ASRC};
        tbl[7]  = '{11'b11111000000, 1, 3, ASRC};
        tbl[8]  = '{11'b11111000010, 1, 4, ASRC};
        tbl[9]  = '{11'b11111000000, 15, 17, ASRC};
        tbl[10] = '{11'b00010111111, 1, 2, UB | PCW};
        tbl[11] = '{11'b10110100000, 1, 2, R2L | AOP01 | BR | PCW};
        rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};

        do_reset();
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].n, pc, ew, h);
            chk($sformatf("latency%0d", i), 32'(pc), 32'(tbl[i].lat));
            chk($sformatf("exec_word%0d", i), 32'(ew), 32'(tbl[i].ew));
        end

        do_reset();
        repeat (16) run_instr(11'b10001011000, 1, pc, ew, h);
        chk("retired_wrap", 32'(retired), 32'd0);

        run_instr(11'b11111000000, 0, pc, ew, h);
        chk("timeout_no_pcwrite", 32'(pc), 32'hFFFFFFFF);
        chk("timeout_halted", 32'(h), 32'd1);
        do_reset();

        run_instr(11'b11111111111, 1, pc, ew, h);
        chk("illegal_halted", 32'(h), 32'd1);
        do_reset();

        run_instr(11'b10110101000, 1, pc, ew, h);
`ifdef MAINDEC_MC_CBNZ_EN
        chk("cbnz_word", 32'(ew), 32'(R2L | AOP01 | BR | PCW));
        chk("cbnz_latency", 32'(pc), 32'd2);
`else
        chk("cbnz_illegal", 32'(illegal_op), 32'd1);
`endif
        do_reset();

        run_instr(11'b10001011000, 1, pc, ew, h);
        @(negedge clk); instr_valid = 1'b1; Op = 11'b11111000010; mem_ack = 1'b0;
        #1 chk("ld_fetch", 32'(pack()), 32'(RDY));
        @(negedge clk); instr_valid = 1'b0;
        #1 chk("ld_decode", 32'(pack()), 32'd0);
        @(negedge clk);
        #1 chk("ld_exec", 32'(pack()), 32'(ASRC));
        @(negedge clk);
        #1 chk("ld_mem", 32'(pack()), 32'(MR));
        @(negedge clk); reset_n = 1'b0; mem_ack = 1'b1;
        #1 chk("reset_in_mem", 32'(pack()), 32'(RDY));
        @(negedge clk); reset_n = 1'b1;
        #1 chk("fetch_after_mem_reset", 32'(pack()), 32'(RDY));
        chk("retired_cleared", 32'(retired), 32'd0);
        model_ret = 0;

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 7))
                0: op = 11'b11111000010;
                1: op = 11'b11111000000;
                2: op = {8'b10110100, 3'($urandom)};
                3: op = rops[$urandom_range(0, 3)];
                4: op = {6'b000101, 5'($urandom)};
                5: op = 11'($urandom);
                6: op = {8'b10110101, 3'($urandom)};
                default: op = rops[$urandom_range(0, 3)];
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); instr_valid = 1'b0; mem_ack = 1'($urandom); Op = 11'($urandom);
                #1 chk("idle_fetch", 32'(pack()), 32'(RDY));
            end
            run_instr(op, $urandom_range(1, 5), pc, ew, h);
            if (h) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/maindec_mc.md
MAINDEC_MC -- requirements
Module: maindec_mc

Interface
REQ-001 SHALL have parameter OP_W, default 11, opcode field width; legal values 11 only (wider values reserved).
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have parameter MEM_WAIT_MAX, default 15, timeout limit in cycles for a memory handshake.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 instr_valid  in  1  Op is valid and held until accepted.
REQ-007 Op  in  OP_W  opcode bits [31:21] of the instruction.
REQ-008 instr_ready  out  1  controller accepts Op this cycle (FETCH state).
REQ-009 mem_ack  in  1  data memory completed the requested access.
REQ-010 Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Uncondbranch  out  1 each  datapath controls, valid for the current state only.
REQ-011 ALUOp  out  2  00 add, 01 pass-B/zero-test, 10 R-type funct decode.
REQ-012 PCWrite  out  1  one-cycle pulse updating PC at instruction retire.
REQ-013 illegal_op  out  1  sticky flag, undefined opcode accepted.
REQ-014 mem_timeout  out  1  sticky flag, mem_ack not seen within MEM_WAIT_MAX cycles.
REQ-015 retired  out  CNT_W  count of retired instructions.

Function
REQ-016 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT; encoding free.
REQ-017 FETCH: instr_ready=1; on instr_valid=1 latch Op, go DECODE; otherwise stay.
REQ-018 DECODE: classify latched Op (LDUR 111_1100_0010, STUR 111_1100_0000, CBZ 101_1010_0???, ADD 100_0101_1000, SUB 110_0101_1000, AND 100_0101_0000, ORR 101_0101_0000, B 000_101?_????); go EXEC; undefined -> set illegal_op, go HALT.
REQ-019 EXEC: LDUR/STUR ALUSrc=1, ALUOp=00, go MEM; R-type ALUOp=10, go WB; CBZ Reg2Loc=1, ALUOp=01, Branch=1, PCWrite=1, go FETCH; B Uncondbranch=1, PCWrite=1, RegWrite=0, go FETCH.
REQ-020 MEM: LDUR MemRead=1, STUR MemWrite=1, Reg2Loc=1 for STUR; hold all controls until mem_ack=1; LDUR then WB, STUR then PCWrite=1 and FETCH.
REQ-021 MEM wait counter SHALL count cycles with mem_ack=0; reaching MEM_WAIT_MAX sets mem_timeout and goes HALT.
REQ-022 WB: RegWrite=1, MemtoReg=1 for LDUR else 0, PCWrite=1, go FETCH.
REQ-023 All controls not named for a state SHALL be 0; DECODE drives all controls 0.
REQ-024 Latency FETCH-accept to PCWrite: R-type 3, CBZ/B 2, STUR 2+N, LDUR 3+N cycles (N = MEM cycles incl. ack cycle, N>=1).
REQ-025 retired SHALL increment by 1 on every PCWrite pulse and wrap from 2^CNT_W-1 to 0.
REQ-026 HALT SHALL be absorbing: instr_ready=0, all controls 0, only reset exits.
REQ-027 mem_ack outside MEM SHALL be ignored; instr_valid outside FETCH SHALL be ignored.

Reset
REQ-028 reset_n=0 at a rising edge SHALL force FETCH, clear latched Op, wait counter, retired, illegal_op, mem_timeout; any instruction in progress is abandoned without PCWrite.
REQ-029 Outputs during and one cycle after reset SHALL equal FETCH values (instr_ready=1, all controls 0).

Configuration
REQ-030 Macro MAINDEC_MC_CBNZ_EN defined: opcode 101_1010_1??? decoded as CBNZ, same controls as CBZ plus Branch asserted with ALUOp=01, counted as retired; undefined: that opcode is illegal (REQ-018).

Verification
REQ-031 Op=100_0101_1000 valid in FETCH -> DECODE, EXEC ALUOp=10, WB RegWrite=1, PCWrite at cycle 3, retired=1.
REQ-032 LDUR with mem_ack after 3 cycles -> MemRead=1 held 3 cycles, WB MemtoReg=1 RegWrite=1, PCWrite at cycle 6.
REQ-033 STUR with mem_ack stuck 0, MEM_WAIT_MAX=15 -> mem_timeout=1 after 15 MEM cycles, HALT, instr_ready=0 until reset.
REQ-034 Op=000_1010_0000 (B) -> Uncondbranch=1, RegWrite=0, PCWrite at cycle 2; Op=111_1111_1111 -> illegal_op=1, HALT.
REQ-035 CNT_W=4, 16 ADD instructions -> retired wraps to 0; reset_n=0 during LDUR MEM -> no PCWrite, retired=0, FETCH next cycle.
REQ-036 Op=101_1010_1000 -> CBNZ branch controls with MAINDEC_MC_CBNZ_EN, illegal_op=1 without.
